muldiv_scheduler: RTL and testbench

Sequences the shared iterative multiply/divide/carry-less-multiply unit for the execute stage. Accepts decoded mult/division/bitc instructions and issues one start pulse with a unit select. Holds the pipeline stalled for the op's latency, then emits a one-cycle writeback strobe. Also flags RAW hazards against the pending destination register and handles pipeline flush (kill).

---
 rtl/muldiv_scheduler.sv | 138 +++++++++++++
 tb/tb_muldiv_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_scheduler.sv
// Issue/stall/writeback sequencer for the shared iterative mul/div/clmul unit.
// One op in flight: accept in IDLE, count down in RUN, strobe writeback in WB.
module muldiv_scheduler #(
    parameter int unsigned MUL_CYCLES   = 4,
    parameter int unsigned DIV_CYCLES   = 33,
    parameter int unsigned CLMUL_CYCLES = 32,
    parameter int unsigned CW           = 6
) (
    input  logic       reset,
    input  logic       clock,
    input  logic       issue_valid,
    input  logic       issue_mult,
    input  logic       issue_division,
    input  logic       issue_bitc,
    input  logic [4:0] issue_waddr,
    input  logic       issue_wren,
    input  logic [4:0] issue_raddr1,
    input  logic [4:0] issue_raddr2,
    input  logic       issue_rden1,
    input  logic       issue_rden2,
    input  logic       flush,
    input  logic       unit_early_done,
    output logic       unit_start,
    output logic [1:0] unit_sel,
    output logic       unit_kill,
    output logic       stall,
    output logic       busy,
    output logic       hazard,
    output logic       wb_valid,
    output logic [4:0] wb_waddr,
    output logic       wb_wren
);

    typedef enum logic [1:0] {StIdle, StRun, StWb} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [4:0]    waddr_q, waddr_d;
    logic          wren_q, wren_d;
    logic          start_q, start_d;

    logic          req;
    logic          accept;
    logic [1:0]    req_sel;
    logic [CW-1:0] req_lat;
    logic          src1_hit;
    logic          src2_hit;

    assign req    = issue_valid & (issue_mult | issue_division | issue_bitc);
    assign accept = (state_q == StIdle) & req & ~flush;

    // Division outranks mult, mult outranks bitc when decode sets several flags.
    always_comb begin
        req_sel = 2'b11;
        req_lat = CW'(CLMUL_CYCLES - 1);
        if (issue_division) begin
            req_sel = 2'b10;
            req_lat = CW'(DIV_CYCLES - 1);
        end else if (issue_mult) begin
            req_sel = 2'b01;
            req_lat = CW'(MUL_CYCLES - 1);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        waddr_d = waddr_q;
        wren_d  = wren_q;
        start_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StRun;
                    cnt_d   = req_lat;
                    sel_d   = req_sel;
                    waddr_d = issue_waddr;
                    wren_d  = issue_wren;
                    start_d = 1'b1;
                end
            end
            StRun: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end
                if (flush) begin
                    state_d = StIdle;
                    sel_d   = 2'b00;
                end else if ((cnt_q == '0) || unit_early_done) begin
                    state_d = StWb;
                end
            end
            StWb: begin
                state_d = StIdle;
                sel_d   = 2'b00;
            end
            default: begin
                state_d = StIdle;
                sel_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sel_q   <= 2'b00;
            waddr_q <= 5'd0;
            wren_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            waddr_q <= waddr_d;
            wren_q  <= wren_d;
            start_q <= start_d;
        end
    end

    assign unit_start = start_q;
    assign unit_sel   = sel_q;
    assign busy       = (state_q != StIdle);
    assign stall      = accept | (state_q == StRun);
    assign unit_kill  = flush & ((state_q == StRun) | (state_q == StWb));
    assign wb_valid   = (state_q == StWb);
    assign wb_waddr   = wb_valid ? waddr_q : 5'd0;
    assign wb_wren    = wb_valid & wren_q;

    // Register x0 never carries a dependency.
    assign src1_hit = issue_rden1 & (issue_raddr1 == waddr_q);
    assign src2_hit = issue_rden2 & (issue_raddr2 == waddr_q);
    assign hazard   = busy & wren_q & (waddr_q != 5'd0) & (src1_hit | src2_hit);

endmodule

// File: tb/tb_muldiv_scheduler.sv
// Directed bench for muldiv_scheduler: vector table for single ops plus
// hand-written flush, hazard and async-reset sequences.
module tb_muldiv_scheduler;

    logic       reset, clock;
    logic       issue_valid, issue_mult, issue_division, issue_bitc;
    logic [4:0] issue_waddr, issue_raddr1, issue_raddr2;
    logic       issue_wren, issue_rden1, issue_rden2;
    logic       flush, unit_early_done;
    logic       unit_start, unit_kill, stall, busy, hazard, wb_valid, wb_wren;
    logic [1:0] unit_sel;
    logic [4:0] wb_waddr;

    int checks = 0;
    int passed = 0;

    muldiv_scheduler #(
        .MUL_CYCLES  (4),
        .DIV_CYCLES  (33),
        .CLMUL_CYCLES(32),
        .CW          (6)
    ) dut (
        .reset          (reset),
        .clock          (clock),
        .issue_valid    (issue_valid),
        .issue_mult     (issue_mult),
        .issue_division (issue_division),
        .issue_bitc     (issue_bitc),
        .issue_waddr    (issue_waddr),
        .issue_wren     (issue_wren),
        .issue_raddr1   (issue_raddr1),
        .issue_raddr2   (issue_raddr2),
        .issue_rden1    (issue_rden1),
        .issue_rden2    (issue_rden2),
        .flush          (flush),
        .unit_early_done(unit_early_done),
        .unit_start     (unit_start),
        .unit_sel       (unit_sel),
        .unit_kill      (unit_kill),
        .stall          (stall),
        .busy           (busy),
        .hazard         (hazard),
        .wb_valid       (wb_valid),
        .wb_waddr       (wb_waddr),
        .wb_wren        (wb_wren)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       mult;
        logic       div;
        logic       bitc;
        logic [4:0] waddr;
        logic       wren;
        int         early_at;
        int         flush_at;
        logic [1:0] exp_sel;
        int         exp_wb;
        int         exp_last_stall;
        int         exp_last_busy;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_mult = 0; issue_division = 0; issue_bitc = 0;
        issue_waddr = 0; issue_wren = 0; issue_raddr1 = 0; issue_raddr2 = 0;
        issue_rden1 = 0; issue_rden2 = 0; flush = 0; unit_early_done = 0;
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic m, input logic d, input logic b, input logic [4:0] wa,
                         input logic we);
        issue_valid = 1; issue_mult = m; issue_division = d; issue_bitc = b;
        issue_waddr = wa; issue_wren = we;
    endtask

    initial begin
        // mult div bitc waddr wren early flush sel wb lastStall lastBusy
        vecs[0] = '{1, 0, 0, 5'd5,  1, -1, -1, 2'b01,  5,  4,  5};
        vecs[1] = '{0, 1, 0, 5'd9,  1, -1, -1, 2'b10, 34, 33, 34};
        vecs[2] = '{0, 1, 0, 5'd9,  1, 10, -1, 2'b10, 11, 10, 11};
        vecs[3] = '{0, 0, 1, 5'd3,  1, -1, -1, 2'b11, 33, 32, 33};
        vecs[4] = '{1, 1, 0, 5'd12, 1, -1, -1, 2'b10, 34, 33, 34};
        vecs[5] = '{0, 1, 0, 5'd4,  1, -1,  3, 2'b10, -1,  3,  3};
        vecs[6] = '{1, 0, 1, 5'd31, 0, -1, -1, 2'b01,  5,  4,  5};
        vecs[7] = '{1, 0, 0, 5'd6,  1,  0, -1, 2'b01,  5,  4,  5};
        vecs[8] = '{1, 0, 0, 5'd6,  1,  1, -1, 2'b01,  2,  1,  2};

        idle_inputs();
        reset = 0;
        #12;
        chk("rst_busy", 0, busy, 0);
        chk("rst_sel", 0, unit_sel, 0);
        chk("rst_start", 0, unit_start, 0);
        chk("rst_wb_valid", 0, wb_valid, 0);
        chk("rst_wb_waddr", 0, wb_waddr, 0);
        chk("rst_stall", 0, stall, 0);
        reset = 1;
        tick();

        for (int v = 0; v < 9; v++) begin
            for (int c = 0; c < 40; c++) begin
                idle_inputs();
                if (c == 0) issue(vecs[v].mult, vecs[v].div, vecs[v].bitc, vecs[v].waddr,
                                  vecs[v].wren);
                if (c == vecs[v].early_at) unit_early_done = 1;
                if (c == vecs[v].flush_at) flush = 1;
                #3;
                chk($sformatf("v%0d_stall", v), c, stall, c <= vecs[v].exp_last_stall);
                chk($sformatf("v%0d_busy", v), c, busy,
                    (c >= 1) && (c <= vecs[v].exp_last_busy));
                chk($sformatf("v%0d_wb_valid", v), c, wb_valid, c == vecs[v].exp_wb);
                chk($sformatf("v%0d_start", v), c, unit_start, c == 1);
                chk($sformatf("v%0d_kill", v), c, unit_kill, c == vecs[v].flush_at);
                if (c >= 1 && c <= vecs[v].exp_last_stall)
                    chk($sformatf("v%0d_sel", v), c, unit_sel, vecs[v].exp_sel);
                if (c > vecs[v].exp_last_busy)
                    chk($sformatf("v%0d_sel_idle", v), c, unit_sel, 0);
                if (c == vecs[v].exp_wb) begin
                    chk($sformatf("v%0d_wb_waddr", v), c, wb_waddr, vecs[v].waddr);
                    chk($sformatf("v%0d_wb_wren", v), c, wb_wren, vecs[v].wren);
                end
                tick();
            end
        end

        // Flush a division at cycle 3, mult accepted at cycle 4; a request in RUN is ignored.
        idle_inputs();
        issue(0, 1, 0, 5'd4, 1);
        for (int c = 0; c < 12; c++) begin
            if (c == 1) idle_inputs();
            if (c == 3) flush = 1;
            if (c == 4) begin
                flush = 0;
                issue(1, 0, 0, 5'd8, 1);
            end
            if (c == 5) idle_inputs();
            if (c == 6) issue(0, 0, 1, 5'd2, 1);
            if (c == 7) idle_inputs();
            #3;
            chk("fl_wb_valid", c, wb_valid, c == 9);
            chk("fl_start", c, unit_start, (c == 1) || (c == 5));
            chk("fl_stall", c, stall, (c <= 8));
            if (c == 3) chk("fl_kill", c, unit_kill, 1);
            if (c == 5) chk("fl_sel", c, unit_sel, 2'b01);
            if (c == 9) chk("fl_wb_waddr", c, wb_waddr, 5'd8);
            if (c == 10) chk("fl_busy", c, busy, 0);
            tick();
        end

        // Hazard against pending destination.
        idle_inputs();
        issue(1, 0, 0, 5'd7, 1);
        issue_rden2 = 1; issue_raddr2 = 5'd7;
        #3;
        chk("hz_idle", 0, hazard, 0);
        tick();
        idle_inputs();
        issue_rden2 = 1; issue_raddr2 = 5'd7;
        #1; chk("hz_src2", 1, hazard, 1);
        issue_rden2 = 0;
        #1; chk("hz_rden2_off", 1, hazard, 0);
        issue_rden1 = 1; issue_raddr1 = 5'd7;
        #1; chk("hz_src1", 1, hazard, 1);
        issue_raddr1 = 5'd6;
        #1; chk("hz_src1_miss", 1, hazard, 0);
        for (int c = 0; c < 6; c++) tick();
        idle_inputs();
        issue(1, 0, 0, 5'd0, 1);
        tick();
        idle_inputs();
        issue_rden2 = 1; issue_raddr2 = 5'd0;
        #1; chk("hz_x0", 1, hazard, 0);
        for (int c = 0; c < 6; c++) tick();

        // Async reset at cycle 2 of a mult: everything clears, no writeback follows.
        idle_inputs();
        issue(1, 0, 0, 5'd5, 1);
        tick();
        idle_inputs();
        tick();
        reset = 0;
        #1;
        chk("ar_busy", 2, busy, 0);
        chk("ar_stall", 2, stall, 0);
        chk("ar_sel", 2, unit_sel, 0);
        chk("ar_start", 2, unit_start, 0);
        chk("ar_wb_valid", 2, wb_valid, 0);
        chk("ar_wb_waddr", 2, wb_waddr, 0);
        chk("ar_wb_wren", 2, wb_wren, 0);
        chk("ar_kill", 2, unit_kill, 0);
        chk("ar_hazard", 2, hazard, 0);
        #2;
        reset = 1;
        for (int c = 3; c < 10; c++) begin
            tick();
            #2;
            chk("ar_no_wb", c, wb_valid, 0);
        end
        tick();
        issue(1, 0, 0, 5'd11, 1);
        for (int c = 0; c < 8; c++) begin
            if (c == 1) idle_inputs();
            #3;
            chk("ar_re_wb", c, wb_valid, c == 5);
            if (c == 5) chk("ar_re_waddr", c, wb_waddr, 5'd11);
            tick();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
